// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: shared NOP encoding, default reset PC and IF/ID record type for the OTTER pipeline
package otter_pipe_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;
    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry skid register (CLK, RST_N, flush, IF_ID_Write, f_vld, imem_data in; cur_instr out) keeping the in-flight word across IF/ID holds
module fetch_skid_buffer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        flush,
    input  logic        IF_ID_Write,
    input  logic        f_vld,
    input  logic [31:0] imem_data,
    output logic [31:0] cur_instr
);
    logic [31:0] skid_instr;
    logic        skid_vld;
    assign cur_instr = skid_vld ? skid_instr : imem_data;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            skid_instr <= '0;
            skid_vld   <= 1'b0;
        end else if (flush || IF_ID_Write) begin
            skid_vld <= 1'b0;
        end else if (f_vld && !skid_vld) begin
            skid_instr <= imem_data;
            skid_vld   <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_frontend.sv
// fetch_frontend: PC, imem read control, IF/ID register and stall/flush counters (CLK, RST_N, PCWrite, IF_ID_Write, flush, target, imem_data in; imem_addr, imem_rden, IF_ID_*, stall_cycles, flush_count out)
module fetch_frontend
    import otter_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             flush,
    input  logic [31:0]      target,
    output logic [31:0]      imem_addr,
    output logic             imem_rden,
    input  logic [31:0]      imem_data,
    output logic [31:0]      IF_ID_PC,
    output logic [31:0]      IF_ID_INSTR,
    output logic             IF_ID_VALID,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    logic [31:0] pc;
    logic [31:0] f_pc;
    logic        f_vld;
    logic [31:0] cur_instr;
    if_id_t      if_id;
    logic        advance;
    assign advance     = PCWrite && (IF_ID_Write || !f_vld) && !flush;
    assign imem_rden   = advance && RST_N;
    assign imem_addr   = pc;
    assign IF_ID_PC    = if_id.pc;
    assign IF_ID_INSTR = if_id.instr;
    assign IF_ID_VALID = if_id.valid;
    fetch_skid_buffer u_skid (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .flush      (flush),
        .IF_ID_Write(IF_ID_Write),
        .f_vld      (f_vld),
        .imem_data  (imem_data),
        .cur_instr  (cur_instr)
    );
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc           <= RESET_PC;
            f_pc         <= '0;
            f_vld        <= 1'b0;
            if_id        <= IF_ID_BUBBLE;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (flush) begin
            pc    <= target;
            f_vld <= 1'b0;
            if_id <= IF_ID_BUBBLE;
            if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
        end else begin
            if (IF_ID_Write) if_id <= '{pc: f_pc, instr: f_vld ? cur_instr : NOP_INSTR, valid: f_vld};
            else if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (advance) begin
                pc    <= pc + 32'd4;
                f_pc  <= pc;
                f_vld <= 1'b1;
            end else begin
                f_vld <= f_vld && !IF_ID_Write;
            end
        end
    end
endmodule

// File: tb/tb_fetch_frontend.sv
// tb_fetch_frontend: vector table plus issue-order scoreboard for fetch_frontend
module tb_fetch_frontend;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        PCWrite, IF_ID_Write, flush;
    logic [31:0] target, imem_addr, imem_data, IF_ID_PC, IF_ID_INSTR;
    logic        imem_rden, IF_ID_VALID;
    logic [3:0]  stall_cycles, flush_count;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        p_rden, p_fl, p_ifw, p_rst;
    logic [31:0] p_addr;

    typedef struct {
        logic        pcw, ifw, fl;
        logic [31:0] tgt, addr, ifpc;
        logic        vld;
        logic [3:0]  stall, fcnt;
    } vec_t;
    vec_t tbl[$];

    fetch_frontend #(.CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .flush(flush), .target(target), .imem_addr(imem_addr), .imem_rden(imem_rden),
        .imem_data(imem_data), .IF_ID_PC(IF_ID_PC), .IF_ID_INSTR(IF_ID_INSTR),
        .IF_ID_VALID(IF_ID_VALID), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    always @(posedge CLK) imem_data <= imem_rden ? word(imem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        #2;
        p_rden = imem_rden;
        p_addr = imem_addr;
        p_fl   = flush;
        p_ifw  = IF_ID_Write;
        p_rst  = RST_N;
    end

    always @(negedge RST_N) q.delete();

    always @(posedge CLK) begin
        logic [31:0] e;
        #1;
        if (!RST_N || !p_rst || p_fl) begin
            q.delete();
        end else begin
            if (p_ifw) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("sb_valid", 32'(IF_ID_VALID), 32'd1);
                    chk("sb_pc", IF_ID_PC, e);
                    chk("sb_instr", IF_ID_INSTR, word(e));
                end else begin
                    chk("sb_bubble_valid", 32'(IF_ID_VALID), 32'd0);
                    chk("sb_bubble_instr", IF_ID_INSTR, 32'h0000_0013);
                end
            end
            if (p_rden) q.push_back(p_addr);
        end
    end

    task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic [31:0] tgt);
        PCWrite = pcw;
        IF_ID_Write = ifw;
        flush = fl;
        target = tgt;
    endtask

    initial begin
        tbl.push_back('{1,1,0,0,          32'h4,        0,          0,0,0});
        tbl.push_back('{1,1,0,0,          32'h8,        0,          1,0,0});
        tbl.push_back('{1,1,0,0,          32'hC,        32'h4,      1,0,0});
        tbl.push_back('{1,1,0,0,          32'h10,       32'h8,      1,0,0});
        tbl.push_back('{0,0,0,0,          32'h10,       32'h8,      1,1,0});
        tbl.push_back('{0,0,0,0,          32'h10,       32'h8,      1,2,0});
        tbl.push_back('{0,0,0,0,          32'h10,       32'h8,      1,3,0});
        tbl.push_back('{1,1,0,0,          32'h14,       32'hC,      1,3,0});
        tbl.push_back('{1,1,0,0,          32'h18,       32'h10,     1,3,0});
        tbl.push_back('{1,1,1,32'h100,    32'h100,      0,          0,3,1});
        tbl.push_back('{1,1,0,0,          32'h104,      0,          0,3,1});
        tbl.push_back('{1,1,0,0,          32'h108,      32'h100,    1,3,1});
        tbl.push_back('{1,1,0,0,          32'h10C,      32'h104,    1,3,1});
        tbl.push_back('{0,0,0,0,          32'h10C,      32'h104,    1,4,1});
        tbl.push_back('{0,0,1,32'h200,    32'h200,      0,          0,4,2});
        tbl.push_back('{1,1,0,0,          32'h204,      0,          0,4,2});
        tbl.push_back('{1,1,0,0,          32'h208,      32'h200,    1,4,2});
        tbl.push_back('{1,0,0,0,          32'h208,      32'h200,    1,5,2});
        tbl.push_back('{1,1,0,0,          32'h20C,      32'h204,    1,5,2});
        tbl.push_back('{0,1,0,0,          32'h20C,      32'h208,    1,5,2});
        tbl.push_back('{1,1,0,0,          32'h210,      0,          0,5,2});
        tbl.push_back('{1,1,0,0,          32'h214,      32'h20C,    1,5,2});
        tbl.push_back('{1,1,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,      0,5,3});
        tbl.push_back('{1,1,0,0,          32'h0,        0,          0,5,3});
        tbl.push_back('{1,1,0,0,          32'h4,        32'hFFFF_FFFC, 1,5,3});

        RST_N = 1'b0;
        drive(1, 1, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_rden", 32'(imem_rden), 32'd0);
        chk("rst_valid", 32'(IF_ID_VALID), 32'd0);
        chk("rst_instr", IF_ID_INSTR, 32'h0000_0013);
        chk("rst_ifpc", IF_ID_PC, 32'h0);
        chk("rst_cnts", 32'({stall_cycles, flush_count}), 32'd0);

        @(negedge CLK);
        RST_N = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].tgt);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(IF_ID_VALID), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("v%0d_ifpc", i), IF_ID_PC, tbl[i].ifpc);
            chk($sformatf("v%0d_stall", i), 32'(stall_cycles), 32'(tbl[i].stall));
            chk($sformatf("v%0d_flush", i), 32'(flush_count), 32'(tbl[i].fcnt));
            @(negedge CLK);
        end

        #3 RST_N = 1'b0;
        #1;
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_rden", 32'(imem_rden), 32'd0);
        chk("arst_valid", 32'(IF_ID_VALID), 32'd0);
        chk("arst_instr", IF_ID_INSTR, 32'h0000_0013);
        chk("arst_ifpc", IF_ID_PC, 32'h0);
        chk("arst_stall", 32'(stall_cycles), 32'd0);
        chk("arst_flush", 32'(flush_count), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1 chk("restart_addr1", imem_addr, 32'h4);
        @(posedge CLK);
        #1;
        chk("restart_addr2", imem_addr, 32'h8);
        chk("restart_valid", 32'(IF_ID_VALID), 32'd1);
        chk("restart_ifpc", IF_ID_PC, 32'h0);

        @(negedge CLK);
        drive(0, 0, 0, 0);
        repeat (15) @(posedge CLK);
        #1 chk("sat_stall15", 32'(stall_cycles), 32'd15);
        repeat (5) @(posedge CLK);
        #1;
        chk("sat_stall20", 32'(stall_cycles), 32'd15);
        chk("sat_addr_held", imem_addr, 32'h8);
        @(negedge CLK);
        drive(1, 1, 0, 0);
        repeat (4) @(posedge CLK);
        #1 chk("sat_resume_ifpc", IF_ID_PC, 32'h10);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_frontend.md
# fetch_frontend

Pipeline front end for the OTTER pipelined core: owns the PC, drives the synchronous instruction memory and holds the IF/ID pipeline register. It is the consumer of the stall controls (PCWrite, IF_ID_Write) raised by the load-use hazard detector, and of the branch flush raised from EX. A one-entry skid buffer preserves the in-flight instruction word across stalls, because the memory returns data one cycle after the address.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- CNT_W, 16, width of the saturating performance counters
- CLK  in  1  core clock, all state on posedge
- RST_N  in  1  asynchronous, active-low reset
- PCWrite  in  1  1 = PC may advance; 0 = hold PC (hazard detector)
- IF_ID_Write  in  1  1 = IF/ID may load; 0 = hold IF/ID (hazard detector)
- flush  in  1  taken branch/jump resolved in EX; squash IF and IF/ID
- target  in  32  redirect PC, sampled only when flush=1
- imem_addr  out  32  fetch address (= pc register, combinational)
- imem_rden  out  1  read strobe; imem_data valid on the next cycle
- imem_data  in  32  instruction word for the previous cycle's read
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_INSTR  out  32  instruction in IF/ID (NOP when invalid)
- IF_ID_VALID  out  1  IF/ID holds a real instruction
- stall_cycles  out  CNT_W  saturating count of hold cycles
- flush_count  out  CNT_W  saturating count of flushes

## Operation
- Registers: pc, f_pc, f_vld (read outstanding, data on imem_data this cycle), skid_instr, skid_vld, IF/ID (PC, INSTR, VALID), and both counters.
- cur_instr = skid_vld ? skid_instr : imem_data.
- Fetch slot states: EMPTY (f_vld=0), INFLIGHT (f_vld=1, skid_vld=0), HELD (f_vld=1, skid_vld=1).
- advance = PCWrite && (IF_ID_Write || !f_vld) && !flush. imem_rden = advance.
- Priority is flush > hold > advance.
- flush=1:
  - pc<=target; f_vld<=0; skid_vld<=0.
  - IF/ID<={PC 0, INSTR NOP, VALID 0}.
  - flush_count++ (saturating).
  - PCWrite and IF_ID_Write are ignored.
- IF_ID_Write=1, no flush:
  - IF/ID<={f_pc, f_vld ? cur_instr : NOP, f_vld}.
  - skid_vld<=0.
- IF_ID_Write=0, no flush:
  - IF/ID holds.
  - If INFLIGHT: skid_instr<=imem_data, skid_vld<=1 (slot goes to HELD).
  - stall_cycles++ (saturating).
- advance=1: pc<=pc+4 (mod 2^32, wraps silently); f_pc<=pc; f_vld<=1.
- advance=0 without flush: pc holds; f_vld<=f_vld && !IF_ID_Write.
- NOP = 32'h0000_0013 (addi x0,x0,0).

## Timing
- Reset values:
  - pc=RESET_PC; f_pc=0; f_vld=0; skid_vld=0.
  - IF_ID_PC=0; IF_ID_INSTR=NOP; IF_ID_VALID=0.
  - Both counters 0.
  - imem_addr=RESET_PC; imem_rden=0 while RST_N=0.
- First read: the first posedge after RST_N deasserts issues RESET_PC. That instruction is visible in IF/ID two cycles after issue.
- Steady state: one instruction per cycle, address-to-IF/ID latency 2 cycles.
- Flush at cycle t:
  - t+1: imem_addr=target, rden=1.
  - t+3: target instruction visible in IF/ID.
  - Penalty: 2 bubbles (VALID=0).
- Stall with PCWrite=IF_ID_Write=0 for N cycles: no read issued and no word lost. The held word enters IF/ID on the first cycle with IF_ID_Write=1.
- PCWrite=1 with IF_ID_Write=0 and f_vld=1: PC does not advance (qualified by advance).
- Flush during a stall: the flush wins and the skid buffer is discarded.
- Reset mid-operation: all state returns to reset values immediately. Any outstanding imem_data is ignored.
- Counters stick at 2^CNT_W-1.

## Structure
- otter_pipe_pkg holds:
  - NOP_INSTR constant.
  - Default RESET_PC.
  - Typedef if_id_t {pc, instr, valid}, shared with the ID stage.
- Sub-module fetch_skid_buffer holds the one-entry skid register, implementing cur_instr select and skid_vld control.
- The PC, IF/ID register and counters stay in fetch_frontend.

## Test plan
- Reset release, PCWrite=IF_ID_Write=1, memory returns word = 32'h1000_0000|addr:
  - imem_addr sequence 0,4,8.
  - IF_ID_PC=0 with VALID=1 two cycles after the first read.
- Stall 3 cycles at IF/ID PC=8:
  - IF/ID holds PC=8 and stall_cycles=3.
  - Next IF/ID is PC=12 with its correct word, even though memory drives garbage while no read is issued.
- Flush with target=32'h100 at cycle t:
  - IF_ID_VALID=0 at t+1 and t+2.
  - IF_ID_PC=32'h100 with VALID=1 at t+3.
  - flush_count=1.
- Flush coincident with PCWrite=IF_ID_Write=0 while HELD:
  - Skid word is discarded.
  - Next valid IF/ID PC equals target.
- RST_N pulsed low mid-stream:
  - All outputs return to reset values asynchronously.
  - Fetch restarts at RESET_PC.
- CNT_W=4, 20 stall cycles: stall_cycles saturates at 15.
